// File: rtl/inst_loader_if.sv
// Byte stream from the host and write port into the instruction memory.
// The loader sits on the slave side; the host/memory pair drives the master side.
interface inst_loader_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9
) ();
    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [INSTR_W-1:0] wr_data;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_loader.sv
// Instruction-memory loader: takes a length byte followed by low/high byte
// pairs from the host, writes 9-bit instructions from address 0 upward and
// pulses start/load_done once the last instruction has landed.
module inst_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load_en,
    input  logic              abort,
    inst_loader_if.slave      bus,
    output logic              busy,
    output logic              load_done,
    output logic              start,
    output logic              error,
    output logic [ADDR_W:0]   count
);

    // WR is the write cycle after a good HI byte; no byte is taken while in it.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        LO   = 3'd2,
        HI   = 3'd3,
        WR   = 3'd4,
        FIN  = 3'd5,
        ERR  = 3'd6
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t             state_reg;
    logic [ADDR_W:0]    len_reg;
    logic [ADDR_W:0]    count_reg;
    logic [ADDR_W:0]    count_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic [7:0]         lo_reg;
    logic               wr_en_reg;
    logic [INSTR_W-1:0] wr_data_reg;
    logic               done_reg;
    logic               start_reg;
    logic               error_reg;
    logic               take_byte;

    // A byte is consumed only in the three receiving states, and never when abort wins.
    assign take_byte  = bus.byte_valid && bus.byte_ready && !abort;
    assign count_next = count_reg + CNT_ONE;

    // Session sequencer: state, index/count bookkeeping and all registered strobes.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            count_reg   <= '0;
            addr_reg    <= '0;
            lo_reg      <= '0;
            wr_en_reg   <= 1'b0;
            wr_data_reg <= '0;
            done_reg    <= 1'b0;
            start_reg   <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            done_reg  <= 1'b0;
            start_reg <= 1'b0;
            case (state_reg)
                IDLE, ERR: begin
                    if (load_en) begin
                        count_reg <= '0;
                        addr_reg  <= '0;
                        error_reg <= 1'b0;
                        state_reg <= LEN;
                    end
                end
                LEN: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (take_byte) begin
                        // A zero length byte stands for a full 256-entry image.
                        len_reg   <= (bus.byte_in == 8'd0) ? LEN_FULL
                                                           : (ADDR_W+1)'(bus.byte_in);
                        state_reg <= LO;
                    end
                end
                LO: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (take_byte) begin
                        lo_reg    <= bus.byte_in;
                        state_reg <= HI;
                    end
                end
                HI: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (take_byte) begin
                        if (bus.byte_in[7:1] != 7'd0) begin
                            error_reg <= 1'b1;
                            state_reg <= ERR;
                        end else begin
                            wr_en_reg   <= 1'b1;
                            wr_data_reg <= INSTR_W'({bus.byte_in[0], lo_reg});
                            state_reg   <= WR;
                        end
                    end
                end
                WR: begin
                    // The write strobe is on the bus this cycle; advance past it.
                    count_reg <= count_next;
                    addr_reg  <= addr_reg + ADDR_ONE;
                    if (count_next == len_reg) begin
                        done_reg  <= 1'b1;
                        start_reg <= 1'b1;
                        state_reg <= FIN;
                    end else begin
                        state_reg <= LO;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.byte_ready = (state_reg == LEN) || (state_reg == LO) || (state_reg == HI);
    assign bus.wr_en      = wr_en_reg;
    assign bus.wr_addr    = addr_reg;
    assign bus.wr_data    = wr_data_reg;
    assign busy           = (state_reg != IDLE) && (state_reg != ERR);
    assign load_done      = done_reg;
    assign start          = start_reg;
    assign error          = error_reg;
    assign count          = count_reg;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: directed byte streams, an expected-write/expected-start
// scoreboard filled by the stimulus, and a negedge monitor that drains it.
module tb_inst_loader;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       load_en;
    logic       abort;
    logic       busy;
    logic       load_done;
    logic       start;
    logic       error;
    logic [8:0] count;

    int total = 0;
    int bad   = 0;

    logic [16:0] exp_wr_q[$];    // {addr[7:0], data[8:0]}
    logic [8:0]  exp_start_q[$]; // count expected when start fires

    inst_loader_if #(.ADDR_W(8), .INSTR_W(9)) bus ();

    inst_loader #(.ADDR_W(8), .INSTR_W(9)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .load_en   (load_en),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .load_done (load_done),
        .start     (start),
        .error     (error),
        .count     (count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
                busy, load_done, start, error, count};
    endfunction

    // Monitor: every write and every start pulse must match the next queued expectation.
    always @(negedge Clk) begin
        if (bus.wr_en) begin
            $display("write addr=%0d data=%03h", bus.wr_addr, bus.wr_data);
            if (exp_wr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%03h required none",
                         bus.wr_addr, bus.wr_data);
            end else begin
                logic [16:0] e;
                e = exp_wr_q.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e[16:9]));
                chk("wr_data", 32'(bus.wr_data), 32'(e[8:0]));
            end
        end
        if (start || load_done) begin
            $display("start=%0d load_done=%0d count=%0d", start, load_done, count);
            chk("start_eq_done", 32'(start), 32'(load_done));
            if (exp_start_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_start: got start=1 required 0");
            end else begin
                chk("done_count", 32'(count), 32'(exp_start_q.pop_front()));
            end
        end
    end

    task automatic push_wr(input logic [7:0] a, input logic [8:0] d);
        exp_wr_q.push_back({a, d});
    endtask

    task automatic pulse_load();
        load_en = 1'b1;
        @(posedge Clk); #1;
        load_en = 1'b0;
    endtask

    // Offer one byte after an optional idle gap; returns just after it is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int i;
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge Clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        i = 0;
        while (!bus.byte_ready && i < 100) begin
            @(negedge Clk);
            i++;
        end
        if (!bus.byte_ready) begin
            total++; bad++;
            $display("FAIL byte_timeout: got byte_ready=0 required 1 for byte %02h", b);
            bus.byte_valid = 1'b0;
        end else begin
            @(posedge Clk); #1;
            bus.byte_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int limit);
        int i;
        i = 0;
        @(negedge Clk);
        while (busy && i < limit) begin
            @(negedge Clk);
            i++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic check_drained(input string name);
        chk({name, "_writes_left"}, 32'(exp_wr_q.size()), 32'd0);
        chk({name, "_starts_left"}, 32'(exp_start_q.size()), 32'd0);
    endtask

    initial begin
        Reset          = 1'b0;
        load_en        = 1'b0;
        abort          = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;

        // Reset hold and release.
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset_outs", all_outs(), 32'd0);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("post_reset_outs", all_outs(), 32'd0);

        // Basic two-instruction load with byte_valid held.
        push_wr(8'd0, 9'h1A5);
        push_wr(8'd1, 9'h03C);
        exp_start_q.push_back(9'd2);
        pulse_load();
        @(negedge Clk);
        chk("busy_after_load_en", 32'(busy), 32'd1);
        send_byte(8'h02, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        @(negedge Clk);
        chk("wr_latency", 32'(bus.wr_en), 32'd1);
        chk("ready_in_wr", 32'(bus.byte_ready), 32'd0);
        send_byte(8'h3C, 0);
        send_byte(8'h00, 0);
        @(negedge Clk);
        chk("last_wr", 32'(bus.wr_en), 32'd1);
        @(negedge Clk);
        chk("start_pulse", 32'({start, load_done}), 32'b11);
        chk("count_two", 32'(count), 32'd2);
        @(negedge Clk);
        chk("start_one_cycle", 32'({start, load_done, busy}), 32'd0);
        check_drained("basic");

        // Full 256-instruction image (length byte 0).
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ai;
            ai = 8'(i);
            push_wr(ai, {ai[0], ai ^ 8'h5A});
        end
        exp_start_q.push_back(9'd256);
        pulse_load();
        send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ai;
            ai = 8'(i);
            send_byte(ai ^ 8'h5A, 0);
            send_byte({7'd0, ai[0]}, 0);
        end
        wait_idle(20);
        chk("count_256", 32'(count), 32'd256);
        check_drained("full");

        // Three instructions with random valid gaps.
        push_wr(8'd0, 9'h1A5);
        push_wr(8'd1, 9'h03C);
        push_wr(8'd2, 9'h17E);
        exp_start_q.push_back(9'd3);
        pulse_load();
        send_byte(8'h03, int'($urandom_range(0, 3)));
        send_byte(8'hA5, int'($urandom_range(0, 3)));
        send_byte(8'h01, int'($urandom_range(0, 3)));
        send_byte(8'h3C, int'($urandom_range(0, 3)));
        send_byte(8'h00, int'($urandom_range(0, 3)));
        send_byte(8'h7E, int'($urandom_range(0, 3)));
        send_byte(8'h01, int'($urandom_range(0, 3)));
        wait_idle(20);
        chk("count_gaps", 32'(count), 32'd3);
        check_drained("gaps");

        // Framing error on the second HI byte.
        push_wr(8'd0, 9'h011);
        pulse_load();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        send_byte(8'h22, 0);
        send_byte(8'h82, 0);
        @(negedge Clk);
        chk("error_set", 32'({error, busy}), 32'b10);
        repeat (5) @(negedge Clk);
        chk("error_sticky", 32'({error, bus.byte_ready}), 32'b10);
        check_drained("err");
        push_wr(8'd0, 9'h155);
        exp_start_q.push_back(9'd1);
        pulse_load();
        @(negedge Clk);
        chk("error_cleared", 32'({error, busy}), 32'b01);
        send_byte(8'h01, 0);
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        wait_idle(20);
        check_drained("recover");

        // Abort during the LO byte of instruction 2.
        push_wr(8'd0, 9'h0AA);
        pulse_load();
        send_byte(8'h03, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h00, 0);
        @(negedge Clk);
        while (!bus.byte_ready) @(negedge Clk);
        bus.byte_in    = 8'h33;
        bus.byte_valid = 1'b1;
        abort          = 1'b1;
        @(posedge Clk); #1;
        abort          = 1'b0;
        bus.byte_valid = 1'b0;
        @(negedge Clk);
        chk("abort_idle", 32'({busy, bus.byte_ready}), 32'd0);
        chk("abort_count", 32'(count), 32'd1);
        repeat (4) @(negedge Clk);
        chk("abort_count_hold", 32'(count), 32'd1);
        check_drained("abort");

        // Reset in the middle of a session.
        push_wr(8'd0, 9'h012);
        pulse_load();
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("midreset_outs", all_outs(), 32'd0);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk("after_midreset_outs", all_outs(), 32'd0);
        check_drained("midreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Writes program images into the 256 x 9-bit instruction memory that the fetch stage reads by PC. A host streams bytes over a valid/ready handshake; the block assembles 9-bit instructions, writes them to consecutive addresses from 0, and then pulses `start` so the core resets its PC and begins fetching. It is the write side of the instruction-memory path whose read side is the program counter.

## Interface
- `ADDR_W`, 8, instruction address width (memory depth 2^ADDR_W = 256)
- `INSTR_W`, 9, instruction width

- `Clk`  in  1  clock, all logic on rising edge
- `Reset`  in  1  synchronous, active-low reset
- `load_en`  in  1  one-cycle request to begin a load session; honoured only in IDLE
- `abort`  in  1  cancel the session in progress; takes priority over the byte handshake
- `byte_in`  in  8  host data byte
- `byte_valid`  in  1  `byte_in` is valid
- `byte_ready`  out  1  loader accepts a byte this cycle
- `wr_en`  out  1  instruction-memory write strobe
- `wr_addr`  out  ADDR_W  write address
- `wr_data`  out  INSTR_W  write data
- `busy`  out  1  session in progress (any state other than IDLE or ERR)
- `load_done`  out  1  one-cycle pulse when all instructions are written
- `start`  out  1  one-cycle pulse to the core, coincident with `load_done`
- `error`  out  1  sticky framing error
- `count`  out  ADDR_W+1  instructions written this session (0..256)

## Operation
- States: IDLE, LEN, LO, HI, FIN, ERR.
- A byte is accepted when `byte_valid && byte_ready`. `byte_ready` = 1 only in LEN, LO and HI.
- IDLE: when `load_en` = 1, clear `count`, `wr_addr` and `error`, then go to LEN.
- LEN: the accepted byte is N, the instruction count. N = 0 means 256. Go to LO.
- LO: latch `byte_in` as instr[7:0]. Go to HI.
- HI: check the accepted byte.
  - bits 7:1 nonzero: go to ERR with no write.
  - otherwise instr[8] = bit 0. Next cycle: `wr_en` = 1, `wr_data` = {bit0, low byte}, `wr_addr` = current index.
  - After the write: index and `count` increment. If `count` reaches N, go to FIN; otherwise go to LO.
- FIN: assert `load_done` and `start` for exactly one cycle, then go to IDLE. `wr_addr` holds its last value.
- ERR: `error` = 1. The block stays in ERR until `load_en` = 1, which clears `error` and enters LEN. No `start` is ever issued from ERR.
- `abort` in LEN, LO or HI: go to IDLE next cycle.
  - The byte offered in the same cycle is not accepted.
  - No write and no `start`.
  - Writes already performed remain in memory, and `count` holds.
- `load_en` while busy is ignored.
- Index arithmetic is ADDR_W bits. After the 256th write, `wr_addr` wraps to 0 but is never used again, because FIN follows. `count` is ADDR_W+1 bits and reads 256.

## Timing
- Reset (`Reset` = 0 at an edge): state IDLE. All outputs are 0: `byte_ready`, `wr_en`, `wr_addr`, `wr_data`, `busy`, `load_done`, `start`, `error`, `count`.
- Reset mid-session aborts silently; no write or pulse follows.
- Write latency: `wr_en` is asserted the cycle after the HI byte is accepted.
- `wr_en` is registered. The loader does not accept a byte in the write cycle (`byte_ready` = 0), so each instruction takes at least 3 cycles.
- `load_done`/`start` assert the cycle after the final `wr_en`.
- Minimum session length: 1 + 3N + 1 cycles after `load_en`.
- `busy` rises the cycle after `load_en` and falls in the cycle after FIN.
- `byte_valid` may drop at any time. The loader waits in its current state indefinitely with no timeout.

## Test plan
- Reset hold, then release → all outputs 0 and `byte_ready` = 0 until `load_en`.
- `load_en`, then bytes 0x02, 0xA5, 0x01, 0x3C, 0x00 with `byte_valid` held → writes 0x1A5 @0 and 0x03C @1, `count` = 2, then one-cycle `start` = `load_done` = 1, then IDLE.
- N = 0x00 followed by 512 bytes → 256 writes at addresses 0..255, `count` = 256, then `start`.
- Random `byte_valid` gaps during a 3-instruction load → identical writes and values to the gap-free case, with no duplicated or dropped bytes.
- HI byte 0x82 on the second instruction → only address 0 written, `error` = 1 and stays 1, no `start`; a following `load_en` clears `error` and a new load succeeds.
- `abort` during the LO byte of instruction 2, and separately `Reset` = 0 mid-session → no further `wr_en`, no `start`, IDLE next cycle; `count` = 1 after the abort, and all outputs 0 after the reset.
